// File: rtl/fpu_arbiter_ctrl.sv
// Two-requester round-robin sequencer in front of a single-issue FPU.
// Holds operands stable for a per-op settling window, then returns the result to the winner.
module fpu_arbiter_ctrl #(
   parameter int unsigned LAT_ADD = 1,
   parameter int unsigned LAT_SUB = 1,
   parameter int unsigned LAT_MUL = 2,
   parameter int unsigned LAT_DIV = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [1:0]  req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [1:0]  req1_op,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_result,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_result,
   output logic [31:0] fpu_a,
   output logic [31:0] fpu_b,
   output logic [1:0]  fpu_op,
   input  logic [31:0] fpu_result,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t      state, state_nxt;
   logic        grant, owner, last_grant;
   logic        accept, rsp_fire;
   logic [3:0]  cnt;
   logic [31:0] res_q;
   logic [1:0]  op_sel;

   function automatic logic [3:0] lat_m1(input logic [1:0] op);
      case (op)
         2'b00:   lat_m1 = 4'(LAT_ADD - 1);
         2'b01:   lat_m1 = 4'(LAT_SUB - 1);
         2'b10:   lat_m1 = 4'(LAT_MUL - 1);
         default: lat_m1 = 4'(LAT_DIV - 1);
      endcase
   endfunction

   // On contention the port that did not win last time goes first.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) grant = ~last_grant;
      else if (req1_valid)          grant = 1'b1;
   end

   assign accept   = (state == IDLE) && (req0_valid || req1_valid);
   assign rsp_fire = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);
   assign op_sel   = grant ? req1_op : req0_op;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EXEC;
         EXEC:    if (cnt == 4'd0) state_nxt = RESP;
         RESP:    if (rsp_fire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req0_ready  = (state == IDLE) && req0_valid && !grant;
      req1_ready  = (state == IDLE) && req1_valid && grant;
      rsp0_valid  = (state == RESP) && !owner;
      rsp1_valid  = (state == RESP) && owner;
      rsp0_result = rsp0_valid ? res_q : 32'd0;
      rsp1_result = rsp1_valid ? res_q : 32'd0;
      busy        = (state != IDLE);
   end

   // fpu_result is only trusted on the last EXEC cycle, when cnt has reached zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fpu_a      <= 32'd0;
         fpu_b      <= 32'd0;
         fpu_op     <= 2'd0;
         res_q      <= 32'd0;
         cnt        <= 4'd0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
      end else if (accept) begin
         fpu_a      <= grant ? req1_a : req0_a;
         fpu_b      <= grant ? req1_b : req0_b;
         fpu_op     <= op_sel;
         owner      <= grant;
         last_grant <= grant;
         cnt        <= lat_m1(op_sel);
      end else if (state == EXEC) begin
         if (cnt != 4'd0) cnt   <= cnt - 4'd1;
         else             res_q <= fpu_result;
      end
   end

endmodule

// File: doc/fpu_arbiter_ctrl.md
Name: fpu_arbiter_ctrl

Overview:
Sequencer and arbiter that shares one single-issue floating-point unit (add/sub/mul/div, 2-bit op select) between two requesters. It accepts one operation at a time through valid/ready handshakes and applies round-robin fairness. Operands and op stay registered and stable for a per-op multicycle settling window. The captured result is returned on the winning requester's response channel. It sits between the two client datapaths and the FPU instance; the FPU itself is outside this block.

Parameters:
LAT_ADD, 1, cycles fpu_result needs to settle for op 2'b00 (min 1, max 15)
LAT_SUB, 1, settling cycles for op 2'b01 (min 1, max 15)
LAT_MUL, 2, settling cycles for op 2'b10 (min 1, max 15)
LAT_DIV, 4, settling cycles for op 2'b11 (min 1, max 15)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready
req0_a / req0_b  in  32  requester 0 IEEE-754 single operands
req0_op  in  2  00 add, 01 sub, 10 mul, 11 div
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
rsp0_valid  out  1  result for requester 0 available
rsp0_ready  in  1  requester 0 consumes result
rsp0_result  out  32  result word
rsp1_valid, rsp1_ready, rsp1_result  same as rsp0, for requester 1
fpu_a / fpu_b  out  32  registered operands to the FPU
fpu_op  out  2  registered op select to the FPU
fpu_result  in  32  FPU result (combinational from fpu_*)
busy  out  1  high in EXEC or RESP

Behaviour:
- States: IDLE, EXEC, RESP. Reset values: state=IDLE, fpu_a=fpu_b=0, fpu_op=0, result reg=0, cnt=0, owner=0, last_grant=1. All rsp*_valid=0, busy=0.
- IDLE: round-robin grant computed combinationally.
  - Only one valid: that port wins.
  - Both valid: the port not equal to last_grant wins, so port 0 wins first after reset.
  - reqN_ready=1 only for the winner, only in IDLE. Ready never asserts without that port's valid.
- Accept (winner valid&ready): latch a/b/op into fpu_a/fpu_b/fpu_op, owner=winner, last_grant=winner, cnt=LAT_op-1. Next state EXEC.
- EXEC: fpu_* held constant.
  - cnt!=0: decrement cnt.
  - cnt==0: capture fpu_result into result reg, go to RESP.
  - EXEC lasts exactly LAT_op cycles.
- RESP: rsp[owner]_valid=1 and rsp[owner]_result=result reg. The other port's rsp_valid=0 and its result=0.
  - Valid holds and result is stable until rsp_ready. On valid&ready, go to IDLE next cycle.
- Result outputs are registered; fpu_* outputs are registered. ready is combinational from state and valid only, never from rsp_ready.
- Accept-to-rsp_valid latency = LAT_op+1 cycles. Minimum issue interval = LAT_op+2 cycles; no accept is allowed in RESP.
- A request arriving while busy is held off: ready=0. The requester must hold valid/a/b/op stable until accepted.
- rsp_ready asserted outside RESP, or by a non-owner: ignored.
- Reset asserted mid-EXEC/RESP: immediate return to reset values. The in-flight operation is discarded; no response is produced.
- fpu_result is sampled only on the final EXEC cycle; glitches in earlier cycles have no effect.
- The FPU's unmapped/default op behaviour is irrelevant: the op is always one of the four.

Test Plan:
- Reset, then req0 alone, add, a=0x3F800000, b=0x40000000 -> req0_ready in the same cycle. fpu_op=00 one cycle later. rsp0_valid 2 cycles after accept with rsp0_result=0x40400000; rsp1_valid stays 0.
- req1 div, a=0x40C00000, b=0x40000000, LAT_DIV=4 -> fpu_* stable for 4 EXEC cycles. rsp1_result=0x40400000 5 cycles after accept.
- Both valid simultaneously after reset, repeated 4 times -> grants alternate 0,1,0,1. Non-granted ready=0 in every cycle.
- Hold rsp0_ready=0 for 10 cycles in RESP -> rsp0_valid and result stable, busy=1, req1_ready=0 throughout. Releasing rsp_ready -> IDLE next cycle, then req1 accepted.
- Pulse rst_n low during EXEC of a mul -> all outputs 0 immediately, no rsp_valid afterwards. The next request after reset is granted to port 0.
- fpu_result model driving garbage on every cycle except the last EXEC cycle -> captured result equals the last-cycle value only.
